datapath_mc: RTL and testbench
==============================

// Module: datapath_mc
// PURPOSE
//  Parametrised successor to the fixed 8-bit GameBoy datapath. It holds the register file (NREGS x DATA_W),
//  PC, SP, MAR, MDR, IR and ZNHC flags, plus an 8-op ALU/16-bit address adder.
//  It executes one externally supplied micro-op per valid/ready handshake and owns a req/ack
//  memory port with wait states. It sits between control_path (micro-op source) and sram or a bus arbiter.
// PARAMETERS
//  DATA_W   8   data/register width; address width AW = 2*DATA_W
//  NREGS    8   register-file entries (>=2); RS = $clog2(NREGS)
//  TIMEOUT  15  mem_ack watchdog limit in cycles (only with DATAPATH_MEM_TIMEOUT_EN)
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous active-high reset
//  uop_valid  in   1        micro-op present
//  uop_ready  out  1        datapath accepts micro-op this cycle
//  uop_alu_op in   4        0 PASSA,1 ADD,2 ADC,3 SUB,4 AND,5 OR,6 XOR,7 INC16,8 DEC16,9 PASS16; others = PASSA
//  uop_src_a  in   3        0 REG[rsel_a],1 REG[rsel_b],2 SPl,3 SPh,4 PCl,5 PCh,6 MDR,7 IMM
//  uop_src_b  in   3        same encoding as src_a
//  uop_rsel_a in   RS       register select A; also the REG write target
//  uop_rsel_b in   RS       register select B
//  uop_imm    in   DATA_W   immediate operand
//  uop_dest   in   4        0 NONE,1 REG,2 SPl,3 SPh,4 PCl,5 PCh,6 MDR,7 MARl,8 MARh,9 PC16,10 SP16,11 MAR16
//  uop_ldflg  in   1        commit ALU flags
//  uop_mem    in   2        0 NONE,1 READ MAR->MDR,2 WRITE MDR->MAR,3 FETCH PC->IR
//  mem_req    out  1        memory request
//  mem_we     out  1        write strobe (valid with mem_req)
//  mem_addr   out  AW       request address
//  mem_wdata  out  DATA_W   write data (= MDR)
//  mem_ack    in   1        memory completes the request this cycle
//  mem_rdata  in   DATA_W   read data, sampled when mem_ack=1
//  ir/pc/sp   out  DATA_W/AW/AW  current IR, PC, SP
//  flags      out  4        {Z,N,H,C}
//  reg_window out  NREGS*DATA_W  register dump; REG[i] in bits [i*DATA_W +: DATA_W]
//  mem_err    out  1        sticky watchdog error (tied 0 when the feature is out)
// BEHAVIOUR
//  Reset: all registers, PC, SP, MAR, MDR, IR, flags = 0; state IDLE; uop_ready=1; mem_req=0; mem_err=0.
//  FSM IDLE -> (accept with uop_mem!=0) -> MEM -> (mem_ack) -> IDLE. uop_ready = (state==IDLE).
//  Accept cycle (uop_valid&uop_ready):
//   - ALU runs on the selected operands and the result is written to uop_dest at the clock edge.
//   - Flags load only if uop_ldflg.
//  8-bit ops:
//   - ADD/ADC/SUB: Z = result==0, C = carry/borrow out of DATA_W, H = carry/borrow out of bit 3, N = 1 for SUB only.
//   - ADC adds the old C. Logic ops: C=0, N=0, H=1 for AND only.
//  16-bit ops: operand is {inA,inB}, inA = high byte.
//   - INC16/DEC16 wrap modulo 2^AW (0xFFFF+1=0, 0-1=0xFFFF).
//   - 16-bit ops never change flags, even with uop_ldflg.
//   - Dest 9-11 take the AW result; dest 1-8 take the DATA_W result (low byte for 16-bit ops).
//  MEM state:
//   - mem_req=1 with mem_addr/mem_we/mem_wdata held constant until mem_ack.
//   - Address is MAR (READ/WRITE) or PC (FETCH), using the value after the accept-cycle writeback.
//   - On mem_ack: READ loads MDR; FETCH loads IR and does PC+=1 (wrapping); WRITE updates no register.
//   - The ack may arrive in the first MEM cycle, so the minimum mem uop takes 2 cycles.
//  Non-mem uops sustain 1 per cycle back-to-back.
//  Simultaneous events:
//   - Same-cycle dest write and MEM source: the writeback wins.
//   - Dest REG with rsel_a==rsel_b: the read sees the old value (write-after-read).
//  mem_ack outside MEM is ignored. rst during MEM drops mem_req in the next cycle and discards the op.
// CONFIGURATION
//  DATAPATH_MEM_TIMEOUT_EN defined:
//   - Counter clears on entering MEM.
//   - If mem_ack is absent for TIMEOUT cycles: return to IDLE, set mem_err (sticky until rst), leave MDR/IR unchanged.
//  Undefined: MEM waits indefinitely; mem_err=0.
// TESTING
//  T1 rst, then uop PASSA IMM=0x3C dest REG r2 -> next cycle reg_window r2=0x3C, flags=0, uop_ready=1.
//  T2 r0=0xFF, r1=0x01, ADD ldflg dest REG r0 -> r0=0x00, flags Z=1 H=1 C=1 N=0.
//  T3 SP=0x0000, DEC16 srcA SPh srcB SPl dest SP16 -> SP=0xFFFF, flags unchanged.
//  T4 FETCH at PC=0x0100, ack after 3 wait cycles, rdata=0xC3:
//   -> mem_req high 4 cycles, addr stable at 0x0100; then IR=0xC3, PC=0x0101; uop_ready low for 4 cycles.
//  T5 dest MAR16 {0xC0,0x00} + WRITE, MDR=0x5A, ack in first cycle
//   -> mem_addr=0xC000, mem_we=1, wdata=0x5A, 2-cycle uop.
//  T6 (EN defined) READ with no ack -> after 15 cycles: IDLE, mem_err=1, MDR unchanged; rst clears mem_err.

Source files
------------

// File: rtl/datapath_mc.sv
// Parametrised register-file datapath with 8-op ALU, 16-bit address adder and req/ack memory port.
// Define DATAPATH_MEM_TIMEOUT_EN to add the mem_ack watchdog that raises the sticky mem_err flag.
module datapath_mc #(
    parameter int DATA_W  = 8,
    parameter int NREGS   = 8,
    parameter int TIMEOUT = 15,
    localparam int AW     = 2 * DATA_W,
    localparam int RS     = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uop_valid,
    output logic                    uop_ready,
    input  logic [3:0]              uop_alu_op,
    input  logic [2:0]              uop_src_a,
    input  logic [2:0]              uop_src_b,
    input  logic [RS-1:0]           uop_rsel_a,
    input  logic [RS-1:0]           uop_rsel_b,
    input  logic [DATA_W-1:0]       uop_imm,
    input  logic [3:0]              uop_dest,
    input  logic                    uop_ldflg,
    input  logic [1:0]              uop_mem,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [DATA_W-1:0]       ir,
    output logic [AW-1:0]           pc,
    output logic [AW-1:0]           sp,
    output logic [3:0]              flags,
    output logic [NREGS*DATA_W-1:0] reg_window,
    output logic                    mem_err
);

    typedef enum logic {IDLE, MEM} state_t;

    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_ADC   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_INC16 = 4'd7;
    localparam logic [3:0] OP_DEC16 = 4'd8;
    localparam logic [3:0] OP_PAS16 = 4'd9;

    localparam logic [1:0] M_READ  = 2'd1;
    localparam logic [1:0] M_WRITE = 2'd2;
    localparam logic [1:0] M_FETCH = 2'd3;

    state_t            state;
    logic [DATA_W-1:0] regs [NREGS];
    logic [AW-1:0]     mar;
    logic [DATA_W-1:0] mdr;
    logic [1:0]        mkind;

    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] r8;
    logic [AW-1:0]     w;
    logic [AW-1:0]     r16;
    logic [DATA_W-1:0] res8;
    logic              is16;
    logic              arith;
    logic [3:0]        fnew;

    logic [AW-1:0]     pc_wb;
    logic [AW-1:0]     sp_wb;
    logic [AW-1:0]     mar_wb;
    logic [DATA_W-1:0] mdr_wb;
    logic              accept;

    function automatic logic [DATA_W-1:0] pick(
        input logic [2:0]        s,
        input logic [DATA_W-1:0] ra,
        input logic [DATA_W-1:0] rb,
        input logic [AW-1:0]     spv,
        input logic [AW-1:0]     pcv,
        input logic [DATA_W-1:0] mdrv,
        input logic [DATA_W-1:0] immv
    );
        logic [DATA_W-1:0] v;
        case (s)
            3'd0:    v = ra;
            3'd1:    v = rb;
            3'd2:    v = spv[DATA_W-1:0];
            3'd3:    v = spv[AW-1:DATA_W];
            3'd4:    v = pcv[DATA_W-1:0];
            3'd5:    v = pcv[AW-1:DATA_W];
            3'd6:    v = mdrv;
            default: v = immv;
        endcase
        return v;
    endfunction

    assign accept    = uop_valid & uop_ready;
    assign mem_wdata = mdr;

    always_comb begin
        opa = pick(uop_src_a, regs[uop_rsel_a], regs[uop_rsel_b],
                   sp, pc, mdr, uop_imm);
        opb = pick(uop_src_b, regs[uop_rsel_a], regs[uop_rsel_b],
                   sp, pc, mdr, uop_imm);
    end

    always_comb begin
        sum   = '0;
        r8    = opa;
        is16  = 1'b0;
        arith = 1'b0;
        w     = {opa, opb};
        r16   = w;
        case (uop_alu_op)
            OP_ADD: begin
                sum   = {1'b0, opa} + {1'b0, opb};
                arith = 1'b1;
            end
            OP_ADC: begin
                sum   = {1'b0, opa} + {1'b0, opb} + {{DATA_W{1'b0}}, flags[0]};
                arith = 1'b1;
            end
            OP_SUB: begin
                sum   = {1'b0, opa} - {1'b0, opb};
                arith = 1'b1;
            end
            OP_AND:   r8 = opa & opb;
            OP_OR:    r8 = opa | opb;
            OP_XOR:   r8 = opa ^ opb;
            OP_INC16: begin
                is16 = 1'b1;
                r16  = w + AW'(1);
            end
            OP_DEC16: begin
                is16 = 1'b1;
                r16  = w - AW'(1);
            end
            OP_PAS16: is16 = 1'b1;
            default:  r8 = opa;
        endcase
        if (arith) r8 = sum[DATA_W-1:0];
        if (!is16) r16 = {{DATA_W{1'b0}}, r8};
        res8 = r16[DATA_W-1:0];
        // Carry/borrow out of bit 3 recovered from the bit-4 sum and operands
        fnew = {r8 == '0,
                uop_alu_op == OP_SUB,
                arith ? (opa[4] ^ opb[4] ^ sum[4]) : (uop_alu_op == OP_AND),
                arith & sum[DATA_W]};
    end

    always_comb begin
        pc_wb  = pc;
        sp_wb  = sp;
        mar_wb = mar;
        mdr_wb = mdr;
        case (uop_dest)
            4'd2:    sp_wb[DATA_W-1:0]   = res8;
            4'd3:    sp_wb[AW-1:DATA_W]  = res8;
            4'd4:    pc_wb[DATA_W-1:0]   = res8;
            4'd5:    pc_wb[AW-1:DATA_W]  = res8;
            4'd6:    mdr_wb              = res8;
            4'd7:    mar_wb[DATA_W-1:0]  = res8;
            4'd8:    mar_wb[AW-1:DATA_W] = res8;
            4'd9:    pc_wb               = r16;
            4'd10:   sp_wb               = r16;
            4'd11:   mar_wb              = r16;
            default: ;
        endcase
    end

`ifdef DATAPATH_MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign mem_err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            uop_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mkind     <= '0;
            pc        <= '0;
            sp        <= '0;
            mar       <= '0;
            mdr       <= '0;
            ir        <= '0;
            flags     <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
`ifdef DATAPATH_MEM_TIMEOUT_EN
            cnt       <= '0;
            mem_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pc  <= pc_wb;
                        sp  <= sp_wb;
                        mar <= mar_wb;
                        mdr <= mdr_wb;
                        if (uop_dest == 4'd1) regs[uop_rsel_a] <= res8;
                        if (uop_ldflg && !is16) flags <= fnew;
                        if (uop_mem != 2'd0) begin
                            state     <= MEM;
                            uop_ready <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_we    <= uop_mem == M_WRITE;
                            mem_addr  <= (uop_mem == M_FETCH) ? pc_wb : mar_wb;
                            mkind     <= uop_mem;
`ifdef DATAPATH_MEM_TIMEOUT_EN
                            cnt       <= '0;
`endif
                        end
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        uop_ready <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        if (mkind == M_READ) mdr <= mem_rdata;
                        if (mkind == M_FETCH) begin
                            ir <= mem_rdata;
                            pc <= pc + AW'(1);
                        end
`ifdef DATAPATH_MEM_TIMEOUT_EN
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state     <= IDLE;
                        uop_ready <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_win
        assign reg_window[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc: register/flag checks plus a memory-request scoreboard.
module tb_datapath_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        uop_valid;
    logic        uop_ready;
    logic [3:0]  uop_alu_op;
    logic [2:0]  uop_src_a;
    logic [2:0]  uop_src_b;
    logic [2:0]  uop_rsel_a;
    logic [2:0]  uop_rsel_b;
    logic [7:0]  uop_imm;
    logic [3:0]  uop_dest;
    logic        uop_ldflg;
    logic [1:0]  uop_mem;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  ir;
    logic [15:0] pc;
    logic [15:0] sp;
    logic [3:0]  flags;
    logic [63:0] reg_window;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } mreq_t;

    mreq_t sbq[$];

    localparam logic [3:0] PASSA = 0, ADD = 1, ADC = 2, SUB = 3, AND_ = 4;
    localparam logic [3:0] XOR_ = 6, INC16 = 7, DEC16 = 8, PASS16 = 9;
    localparam logic [2:0] S_RA = 0, S_RB = 1, S_SPL = 2, S_SPH = 3;
    localparam logic [2:0] S_MDR = 6, S_IMM = 7;
    localparam logic [3:0] D_NONE = 0, D_REG = 1, D_PCH = 5, D_MDR = 6;
    localparam logic [3:0] D_MARL = 7, D_SP16 = 10, D_MAR16 = 11;
    localparam logic [1:0] M_NO = 0, M_RD = 1, M_WR = 2, M_FE = 3;

    datapath_mc #(.DATA_W(8), .NREGS(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .uop_valid(uop_valid), .uop_ready(uop_ready),
        .uop_alu_op(uop_alu_op), .uop_src_a(uop_src_a), .uop_src_b(uop_src_b),
        .uop_rsel_a(uop_rsel_a), .uop_rsel_b(uop_rsel_b), .uop_imm(uop_imm),
        .uop_dest(uop_dest), .uop_ldflg(uop_ldflg), .uop_mem(uop_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir(ir), .pc(pc), .sp(sp), .flags(flags),
        .reg_window(reg_window), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rg(input int i);
        return reg_window[i*8 +: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [2:0] ra, input logic [2:0] rb, input logic [7:0] imm,
                         input logic [3:0] dest, input logic ld, input logic [1:0] mm);
        @(negedge clk);
        chk("ready_at_issue", uop_ready, 1);
        uop_alu_op = op;
        uop_src_a  = sa;
        uop_src_b  = sb;
        uop_rsel_a = ra;
        uop_rsel_b = rb;
        uop_imm    = imm;
        uop_dest   = dest;
        uop_ldflg  = ld;
        uop_mem    = mm;
        uop_valid  = 1'b1;
        @(posedge clk);
        #1 uop_valid = 1'b0;
    endtask

    task automatic serve(input int waits, input logic [7:0] rd, input bit give,
                         input int exp_cycles, input string tag);
        mreq_t e;
        int    n = 0;
        e = '{we: 1'b0, addr: 16'h0, wdata: 8'h0};
        chk({tag, "_sbq"}, sbq.size(), 1);
        if (sbq.size() > 0) e = sbq.pop_front();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req !== 1'b1) break;
            n++;
            chk({tag, "_addr"}, mem_addr, e.addr);
            chk({tag, "_we"}, mem_we, e.we);
            chk({tag, "_wdata"}, mem_wdata, e.wdata);
            chk({tag, "_busy"}, uop_ready, 0);
            mem_ack   = give && (i == waits);
            mem_rdata = rd;
        end
        mem_ack = 1'b0;
        chk({tag, "_cycles"}, n, exp_cycles);
    endtask

    initial begin
        rst        = 1'b1;
        uop_valid  = 1'b0;
        uop_alu_op = '0;
        uop_src_a  = '0;
        uop_src_b  = '0;
        uop_rsel_a = '0;
        uop_rsel_b = '0;
        uop_imm    = '0;
        uop_dest   = '0;
        uop_ldflg  = 1'b0;
        uop_mem    = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", uop_ready, 1);
        chk("rst_req", mem_req, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_sp", sp, 16'h0000);
        chk("rst_flags", flags, 4'h0);
        chk("rst_regs_lo", reg_window[31:0], 32'h0);
        chk("rst_regs_hi", reg_window[63:32], 32'h0);
        rst = 1'b0;

        issue(PASSA, S_IMM, S_IMM, 3'd2, 3'd0, 8'h3C, D_REG, 1'b0, M_NO);
        @(negedge clk);
        chk("t1_r2", rg(2), 8'h3C);
        chk("t1_flags", flags, 4'h0);
        chk("t1_ready", uop_ready, 1);

        issue(PASSA, S_IMM, S_IMM, 3'd0, 3'd0, 8'hFF, D_REG, 1'b0, M_NO);
        issue(PASSA, S_IMM, S_IMM, 3'd1, 3'd0, 8'h01, D_REG, 1'b0, M_NO);
        issue(ADD, S_RA, S_RB, 3'd0, 3'd1, 8'h00, D_REG, 1'b1, M_NO);
        @(negedge clk);
        chk("t2_r0", rg(0), 8'h00);
        chk("t2_flags", flags, 4'b1011);

        issue(ADC, S_RA, S_RB, 3'd3, 3'd1, 8'h00, D_NONE, 1'b0, M_NO);
        issue(ADC, S_RB, S_RB, 3'd3, 3'd1, 8'h00, D_REG, 1'b1, M_NO);
        @(negedge clk);
        chk("adc_r3", rg(3), 8'h03);
        chk("adc_flags", flags, 4'b0000);

        issue(SUB, S_IMM, S_RB, 3'd4, 3'd1, 8'h10, D_REG, 1'b1, M_NO);
        @(negedge clk);
        chk("sub_r4", rg(4), 8'h0F);
        chk("sub_flags", flags, 4'b0110);

        issue(SUB, S_RB, S_IMM, 3'd5, 3'd1, 8'h02, D_REG, 1'b1, M_NO);
        @(negedge clk);
        chk("borrow_r5", rg(5), 8'hFF);
        chk("borrow_flags", flags, 4'b0111);

        issue(AND_, S_RA, S_IMM, 3'd5, 3'd0, 8'h0F, D_REG, 1'b1, M_NO);
        @(negedge clk);
        chk("and_r5", rg(5), 8'h0F);
        chk("and_flags", flags, 4'b0010);

        issue(XOR_, S_RA, S_IMM, 3'd5, 3'd0, 8'h0F, D_REG, 1'b1, M_NO);
        @(negedge clk);
        chk("xor_r5", rg(5), 8'h00);
        chk("xor_flags", flags, 4'b1000);

        issue(ADD, S_RA, S_RB, 3'd3, 3'd3, 8'h00, D_REG, 1'b0, M_NO);
        @(negedge clk);
        chk("war_r3", rg(3), 8'h06);
        chk("noflg_flags", flags, 4'b1000);

        issue(DEC16, S_SPH, S_SPL, 3'd0, 3'd0, 8'h00, D_SP16, 1'b1, M_NO);
        @(negedge clk);
        chk("t3_sp", sp, 16'hFFFF);
        chk("t3_flags", flags, 4'b1000);
        issue(INC16, S_SPH, S_SPL, 3'd0, 3'd0, 8'h00, D_SP16, 1'b1, M_NO);
        @(negedge clk);
        chk("inc_wrap_sp", sp, 16'h0000);

        issue(PASSA, S_IMM, S_IMM, 3'd0, 3'd0, 8'h01, D_PCH, 1'b0, M_NO);
        @(negedge clk);
        chk("pc_set", pc, 16'h0100);

        sbq.push_back('{we: 1'b0, addr: 16'h0100, wdata: 8'h00});
        issue(PASSA, S_IMM, S_IMM, 3'd0, 3'd0, 8'h00, D_NONE, 1'b0, M_FE);
        serve(3, 8'hC3, 1'b1, 4, "t4");
        chk("t4_ir", ir, 8'hC3);
        chk("t4_pc", pc, 16'h0101);

        issue(PASSA, S_IMM, S_IMM, 3'd0, 3'd0, 8'h5A, D_MDR, 1'b0, M_NO);
        sbq.push_back('{we: 1'b1, addr: 16'hC000, wdata: 8'h5A});
        issue(PASS16, S_IMM, S_RB, 3'd0, 3'd5, 8'hC0, D_MAR16, 1'b0, M_WR);
        serve(0, 8'h00, 1'b1, 1, "t5");

        sbq.push_back('{we: 1'b0, addr: 16'hC010, wdata: 8'h5A});
        issue(PASSA, S_IMM, S_IMM, 3'd0, 3'd0, 8'h10, D_MARL, 1'b0, M_RD);
        serve(1, 8'h77, 1'b1, 2, "rd");

        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
        issue(PASSA, S_MDR, S_IMM, 3'd6, 3'd0, 8'h00, D_REG, 1'b0, M_NO);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_r6", rg(6), 8'h77);
        chk("stray_ack_ir", ir, 8'hC3);
        chk("stray_ack_req", mem_req, 0);

`ifdef DATAPATH_MEM_TIMEOUT_EN
        sbq.push_back('{we: 1'b0, addr: 16'hC010, wdata: 8'h77});
        issue(PASSA, S_IMM, S_IMM, 3'd0, 3'd0, 8'h00, D_NONE, 1'b0, M_RD);
        serve(0, 8'h99, 1'b0, 15, "t6");
        chk("t6_err", mem_err, 1);
        chk("t6_ready", uop_ready, 1);
        issue(PASSA, S_MDR, S_IMM, 3'd7, 3'd0, 8'h00, D_REG, 1'b0, M_NO);
        @(negedge clk);
        chk("t6_mdr", rg(7), 8'h77);
`else
        chk("no_wdog_err", mem_err, 0);
`endif

        issue(PASSA, S_IMM, S_IMM, 3'd0, 3'd0, 8'h00, D_NONE, 1'b0, M_RD);
        @(negedge clk);
        chk("rmem_req", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rmem_drop", mem_req, 0);
        chk("rmem_ready", uop_ready, 1);
        chk("rmem_err", mem_err, 0);
        chk("rmem_pc", pc, 16'h0000);
        chk("rmem_ir", ir, 8'h00);
        chk("rmem_r6", rg(6), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
